uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
// - UART receiver: companion of the team's uart_tx, 8N1 framing (start=0, LSB-first data, stop=1).
// - Oversamples the asynchronous rx line on an external tick strobe and validates start/stop bits.
// - Delivers each byte through a valid/ready output register; flags framing and overrun errors.
// - Sits between the pad-side rx pin and the consumer (FIFO/CPU regs); tick from shared baud gen.
// PARAMETERS
// - DATA_BITS   8   data bits per frame, LSB first
// - OVERSAMPLE  16  sample_tick strobes per bit period (even, >=4)
// PORTS
// - clk          in   1          system clock
// - rst_n        in   1          synchronous active-low reset
// - sample_tick  in   1          1-clk strobe, OVERSAMPLE x baud rate
// - rx           in   1          async serial input, idle high
// - data_out     out  DATA_BITS  received byte, stable while valid
// - valid        out  1          byte available
// - ready        in   1          consumer accepts byte when valid&&ready
// - framing_err  out  1          1-clk pulse: stop bit sampled low
// - overrun      out  1          1-clk pulse: byte completed while previous still unread
// - busy         out  1          high in any state except IDLE
// BEHAVIOUR
// - Reset (rst_n=0 at posedge clk): state=IDLE, counters=0, data_out=0, valid=0,
//   framing_err=0, overrun=0, busy=0; synchronizer flops=1. Reset mid-frame aborts it, no flags.
// - rx passes a 2-FF synchronizer -> rx_s; all decisions use rx_s. Counters advance only on sample_tick.
// - tick_cnt width $clog2(OVERSAMPLE); bit_cnt width $clog2(DATA_BITS+1).
// - FSM (5 states):
//   IDLE:  on tick with rx_s==0 -> START, tick_cnt=0.
//   START: on tick, tick_cnt++; at tick_cnt==OVERSAMPLE/2-1: rx_s==0 -> DATA, tick_cnt=0,
//          bit_cnt=0 (mid-bit aligned); rx_s==1 -> IDLE (glitch rejected, no flag).
//   DATA:  on tick, tick_cnt++; at tick_cnt==OVERSAMPLE-1: shift_reg={rx_s,shift_reg[DATA_BITS-1:1]},
//          tick_cnt=0, bit_cnt++; after sampling bit DATA_BITS-1 -> STOP.
//   STOP:  at tick_cnt==OVERSAMPLE-1: rx_s==1 -> deliver byte, -> IDLE;
//          rx_s==0 -> framing_err pulse next clk, byte discarded, -> BREAK.
//   BREAK: wait for tick with rx_s==1 -> IDLE (line held low never re-triggers start).
// - Delivery (registered, 1 clk after stop-sample): if !valid or (valid&&ready same clk):
//   data_out=shift_reg, valid=1. Else (valid&&!ready): new byte dropped, data_out kept, overrun pulse.
// - valid clears the clk after valid&&ready unless a new byte is delivered that same clk.
// - ready ignored while valid==0. data_out unchanged when valid falls.
// - Latency: rx edge -> start detection 2 clk sync + <=1 tick; stop-sample tick -> valid 1 clk.
// - sample_tick asserted every clk is legal; ticks faster than that are not defined.
// - tx (uart_tx) drives one bit per baud tick; receiver tolerates +/-3% baud mismatch at OVERSAMPLE=16.
// STRUCTURE
// - uart_pkg: rx state enum (IDLE,START,DATA,STOP,BREAK), UART_DATA_BITS=8, UART_OVERSAMPLE=16.
// - Sub-module uart_rx_sync: 2-FF synchronizer, reset value 1, instanced once for rx.
// - Remainder (FSM, counters, shift_reg, output reg) in uart_rx; no other hierarchy.
// TESTING (OVERSAMPLE=16, sample_tick every 4 clk, bit=64 clk; uart_tx as driver where noted)
// - Send 0xA5 via uart_tx, ready=1 -> valid 1 clk after stop sample, data_out=0xA5, no flags.
// - Back-to-back 0x00,0xFF,0x55, ready=1 -> three valid pulses, bytes in order, busy low between frames.
// - rx low for 20 clk (< half bit) then high -> returns to IDLE, no valid, no framing_err.
// - Frame 0x3C with stop bit forced 0, then line low 200 clk -> framing_err 1 pulse, no valid,
//   no new frame until rx high; next frame 0x81 received correctly.
// - ready=0, send 0x11 then 0x22 -> data_out=0x11, valid held, overrun pulse at 0x22; ready=1 pops 0x11.
// - Assert rst_n=0 mid-DATA of 0x77 -> all outputs 0 next clk, busy=0; following 0x42 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry defaults and receiver state encoding.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;

    // Status flags raised by the receiver for one clock.
    typedef struct packed {
        logic framing_err;
        logic overrun;
    } rx_flags_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high serial line.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Reset to 1 so a held-in-reset line looks idle, never like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start/data/stop capture with a valid/ready
// output register, framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = UART_DATA_BITS,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 framing_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic rx_s;

    rx_state_e              state_q, state_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    rx_flags_t              flags_q, flags_d;
    logic                   busy_q, busy_d;
    logic                   deliver_c;
    logic                   stop_bad_c;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Frame sequencer: all counting happens on sample_tick only.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        deliver_c  = 1'b0;
        stop_bad_c = 1'b0;

        if (sample_tick) begin
            unique case (state_q)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state_d    = RX_START;
                        tick_cnt_d = '0;
                    end
                end
                RX_START: begin
                    if (tick_cnt_q == HALF_LAST) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                RX_DATA: begin
                    if (tick_cnt_q == FULL_LAST) begin
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = RX_STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                RX_STOP: begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        if (rx_s) begin
                            deliver_c = 1'b1;
                            state_d   = RX_IDLE;
                        end else begin
                            stop_bad_c = 1'b1;
                            state_d    = RX_BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                RX_BREAK: begin
                    if (rx_s) begin
                        state_d = RX_IDLE;
                    end
                end
                default: begin
                    state_d = RX_IDLE;
                end
            endcase
        end
    end

    // Output register: a pending unread byte wins over a newly completed one.
    always_comb begin
        data_d              = data_q;
        valid_d             = valid_q;
        flags_d.framing_err = stop_bad_c;
        flags_d.overrun     = 1'b0;
        busy_d              = (state_d != RX_IDLE);

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (deliver_c) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                flags_d.overrun = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RX_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            flags_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            flags_q    <= flags_d;
            busy_q     <= busy_d;
        end
    end

    assign data_out    = data_q;
    assign valid       = valid_q;
    assign framing_err = flags_q.framing_err;
    assign overrun     = flags_q.overrun;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized bytes and
// baud skew, checked against a queue of bytes the line is expected to carry.
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_tick = 1'b0;
    logic       rx;
    logic       ready;
    logic [7:0] data_out;
    logic       valid;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int n_rx     = 0;
    int n_ferr   = 0;
    int n_ovr    = 0;
    int tick_div = 0;

    logic [7:0] exp_q[$];

    uart_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .rx          (rx),
        .data_out    (data_out),
        .valid       (valid),
        .ready       (ready),
        .framing_err (framing_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // One sample_tick every 4 clocks: 16 ticks per 64-clock bit.
    always @(posedge clk) begin
        tick_div    <= (tick_div == 3) ? 0 : tick_div + 1;
        sample_tick <= (tick_div == 2);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Consumer side: every accepted byte must be the oldest byte still expected.
    always @(negedge clk) begin
        if (rst_n) begin
            if (framing_err) n_ferr++;
            if (overrun)     n_ovr++;
            if (valid && ready) begin
                logic [31:0] exp;
                exp = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'h1FF;
                check_eq("rx_byte", 32'(data_out), exp);
                n_rx++;
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int per, input int stop_len);
        rx = 1'b0;
        wait_clks(per);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(per);
        end
        rx = stop_v;
        wait_clks(stop_len);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            wait_clks(1);
            k++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] b2b [3];
        b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55;

        rst_n = 1'b0;
        rx    = 1'b1;
        ready = 1'b1;
        wait_clks(3);
        check_eq("rst_data",  32'(data_out),    32'h0);
        check_eq("rst_valid", 32'(valid),       32'h0);
        check_eq("rst_ferr",  32'(framing_err), 32'h0);
        check_eq("rst_ovr",   32'(overrun),     32'h0);
        check_eq("rst_busy",  32'(busy),        32'h0);
        rst_n = 1'b1;
        wait_clks(10);

        // Single byte
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 64, 64);
        wait_drain(200);
        check_eq("a5_count", 32'(n_rx), 32'd1);
        check_eq("a5_ferr",  32'(n_ferr), 32'd0);
        check_eq("a5_ovr",   32'(n_ovr), 32'd0);

        // Back-to-back frames, receiver idle by the end of each stop bit
        foreach (b2b[i]) begin
            exp_q.push_back(b2b[i]);
            send_frame(b2b[i], 1'b1, 64, 64);
            check_eq("b2b_busy_gap", 32'(busy), 32'h0);
        end
        wait_drain(200);
        check_eq("b2b_count", 32'(n_rx), 32'd4);

        // Short low glitch is rejected silently
        base = n_rx;
        rx = 1'b0;
        wait_clks(20);
        rx = 1'b1;
        wait_clks(150);
        check_eq("glitch_busy",  32'(busy), 32'h0);
        check_eq("glitch_valid", 32'(n_rx), 32'(base));
        check_eq("glitch_ferr",  32'(n_ferr), 32'd0);

        // Bad stop bit followed by a long break
        send_frame(8'h3C, 1'b0, 64, 264);
        check_eq("brk_ferr",  32'(n_ferr), 32'd1);
        check_eq("brk_valid", 32'(n_rx), 32'(base));
        check_eq("brk_busy",  32'(busy), 32'h1);
        rx = 1'b1;
        wait_clks(70);
        check_eq("brk_exit_busy", 32'(busy), 32'h0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 64, 64);
        wait_drain(200);
        check_eq("brk_next_count", 32'(n_rx), 32'(base + 1));

        // Overrun while the consumer stalls
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 64, 64);
        send_frame(8'h22, 1'b1, 64, 64);
        wait_clks(40);
        check_eq("ovr_valid", 32'(valid), 32'h1);
        check_eq("ovr_data",  32'(data_out), 32'h11);
        check_eq("ovr_pulse", 32'(n_ovr), 32'd1);
        ready = 1'b1;
        wait_drain(20);
        wait_clks(3);
        check_eq("ovr_pop_valid", 32'(valid), 32'h0);
        check_eq("ovr_hold_data", 32'(data_out), 32'h11);

        // Reset in the middle of the data bits of 0x77
        rx = 1'b0;
        wait_clks(64);
        rx = 1'b1;
        wait_clks(64 * 2 + 20);
        check_eq("mid_busy_pre", 32'(busy), 32'h1);
        rst_n = 1'b0;
        wait_clks(1);
        check_eq("mid_rst_data",  32'(data_out),    32'h0);
        check_eq("mid_rst_valid", 32'(valid),       32'h0);
        check_eq("mid_rst_busy",  32'(busy),        32'h0);
        check_eq("mid_rst_ferr",  32'(framing_err), 32'h0);
        rst_n = 1'b1;
        wait_clks(200);
        check_eq("mid_idle_busy", 32'(busy), 32'h0);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1, 64, 64);
        wait_drain(200);

        // Random bytes, +/-3% baud skew, random idle gaps
        base = n_rx;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            int per;
            b   = 8'($urandom);
            per = int'($urandom_range(62, 66));
            exp_q.push_back(b);
            send_frame(b, 1'b1, per, per);
            wait_clks(int'($urandom_range(0, 80)));
        end
        wait_drain(300);
        check_eq("rand_count", 32'(n_rx), 32'(base + 20));
        check_eq("total_ferr", 32'(n_ferr), 32'd1);
        check_eq("total_ovr",  32'(n_ovr), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
